pixel_accum_rmw: RTL and testbench

- Parametrised per-pixel read-modify-write accumulator; successor to the single-channel running-sum updater.
- Accepts (pixel, new, old) update requests over a valid/ready handshake and computes stored + new − old, saturated.
- Reads and writes the result to single-port SRAM holding truncated sums; sits between the frame-statistics front end and the SRAM controller.
- Adds over its predecessor: per-request mode, configurable read latency, saturation with flag, stop/abort semantics, op counter.

---
 rtl/pixel_accum_rmw_if.sv | 32 +++
 rtl/pixel_accum_rmw.sv | 153 +++++++++++++++
 tb/tb_pixel_accum_rmw.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_accum_rmw_if.sv
// Request handshake and SRAM bus of the pixel read-modify-write accumulator.
// The slave modport is the accumulator's view. The master modport is the view of the front end plus the SRAM.
interface pixel_accum_rmw_if #(
   parameter int DATA_W = 17,
   parameter int SRAM_W = 16,
   parameter int ADDR_W = 20,
   parameter int PX_W   = 10,
   parameter int PY_W   = 9
);
   logic              i_valid;
   logic              o_ready;
   logic              i_mode;
   logic [PX_W-1:0]   i_px;
   logic [PY_W-1:0]   i_py;
   logic [DATA_W-1:0] i_new_data;
   logic [DATA_W-1:0] i_old_data;
   logic [ADDR_W-1:0] o_sram_addr;
   logic              o_sram_oe;
   logic              o_sram_we;
   logic [SRAM_W-1:0] o_sram_wdata;
   logic [SRAM_W-1:0] i_sram_rdata;

   modport slave (
      input  i_valid, i_mode, i_px, i_py, i_new_data, i_old_data, i_sram_rdata,
      output o_ready, o_sram_addr, o_sram_oe, o_sram_we, o_sram_wdata
   );

   modport master (
      output i_valid, i_mode, i_px, i_py, i_new_data, i_old_data, i_sram_rdata,
      input  o_ready, o_sram_addr, o_sram_oe, o_sram_we, o_sram_wdata
   );
endinterface

// File: rtl/pixel_accum_rmw.sv
// Per-pixel read-modify-write accumulator: stored + new - old, saturated, written back to single-port SRAM.
// SRAM words hold the accumulator with the TRUNC low bits dropped.
module pixel_accum_rmw #(
   parameter int DATA_W = 17,
   parameter int SRAM_W = 16,
   parameter int ACC_W  = 18,
   parameter int COLS   = 640,
   parameter int ROWS   = 480,
   parameter int ADDR_W = 20,
   parameter int RD_LAT = 1
) (
   input  logic                  i_50M_clk,
   input  logic                  i_rst_n,
   pixel_accum_rmw_if.slave      acc_if,
   input  logic                  i_stop,
   output logic                  o_sat,
   output logic                  o_abort,
   output logic [31:0]           o_op_cnt
);

   localparam int TRUNC = ACC_W - SRAM_W;
   localparam int SUM_W = ACC_W + 2;

   typedef enum logic [1:0] {IDLE, RD, MOD, WR} state_t;

   state_t              state_q, state_d;
   logic                live_q;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   new_q, new_d;
   logic [DATA_W-1:0]   old_q, old_d;
   logic [2:0]          lat_cnt_q, lat_cnt_d;
   logic [SRAM_W-1:0]   result_q, result_d;
   logic                sat_q, sat_d;
   logic                abort_q, abort_d;
   logic [31:0]         op_cnt_q, op_cnt_d;

   logic                ready;
   logic [ACC_W-1:0]    base;
   logic signed [SUM_W-1:0] sum;

   // Read data lands in the MOD cycle, so the base is taken straight from the bus there.
   always_comb begin
      base = '0;
      if (mode_q) base = ACC_W'(acc_if.i_sram_rdata) << TRUNC;
      sum = $signed(SUM_W'(base)) + $signed(SUM_W'(new_q)) - $signed(SUM_W'(old_q));
   end

   generate
      if (TRUNC > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^sum[TRUNC-1:0];
      end
   endgenerate

   assign ready = live_q && (state_q == IDLE) && !i_stop;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      new_d     = new_q;
      old_d     = old_q;
      lat_cnt_d = lat_cnt_q;
      result_d  = result_q;
      sat_d     = sat_q;
      abort_d   = 1'b0;
      op_cnt_d  = op_cnt_q;

      case (state_q)
         IDLE: begin
            if (acc_if.i_valid && ready) begin
               mode_d    = acc_if.i_mode;
               addr_d    = ADDR_W'(acc_if.i_py) * ADDR_W'(COLS) + ADDR_W'(acc_if.i_px);
               new_d     = acc_if.i_new_data;
               old_d     = acc_if.i_old_data;
               lat_cnt_d = '0;
               state_d   = acc_if.i_mode ? RD : MOD;
            end
         end
         RD: begin
            if (i_stop) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else if (lat_cnt_q == 3'(RD_LAT - 1)) begin
               state_d = MOD;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         MOD: begin
            if (i_stop) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               state_d  = WR;
               sat_d    = 1'b0;
               result_d = sum[ACC_W-1:TRUNC];
               if (sum[SUM_W-1]) begin
                  result_d = '0;
                  sat_d    = 1'b1;
               end else if (|sum[SUM_W-2:ACC_W]) begin
                  result_d = '1;
                  sat_d    = 1'b1;
               end
            end
         end
         WR: begin
            state_d  = IDLE;
            op_cnt_d = op_cnt_q + 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         live_q    <= 1'b0;
         mode_q    <= 1'b0;
         addr_q    <= '0;
         new_q     <= '0;
         old_q     <= '0;
         lat_cnt_q <= '0;
         result_q  <= '0;
         sat_q     <= 1'b0;
         abort_q   <= 1'b0;
         op_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         live_q    <= 1'b1;
         mode_q    <= mode_d;
         addr_q    <= addr_d;
         new_q     <= new_d;
         old_q     <= old_d;
         lat_cnt_q <= lat_cnt_d;
         result_q  <= result_d;
         sat_q     <= sat_d;
         abort_q   <= abort_d;
         op_cnt_q  <= op_cnt_d;
      end
   end

   assign acc_if.o_ready      = ready;
   assign acc_if.o_sram_addr  = addr_q;
   assign acc_if.o_sram_oe    = (state_q == RD) && (lat_cnt_q == '0);
   assign acc_if.o_sram_we    = (state_q == WR);
   assign acc_if.o_sram_wdata = result_q;
   assign o_sat               = (state_q == WR) && sat_q;
   assign o_abort             = abort_q;
   assign o_op_cnt            = op_cnt_q;

endmodule

// File: tb/tb_pixel_accum_rmw.sv
// Directed bench for pixel_accum_rmw: vector table on an RD_LAT=1 instance, hand sequences for reset/stop,
// back-pressure and coherence on an RD_LAT=3 instance.
module tb_pixel_accum_rmw;
   localparam int DATA_W = 17;
   localparam int SRAM_W = 16;
   localparam int ACC_W  = 18;
   localparam int COLS   = 640;
   localparam int ROWS   = 480;
   localparam int ADDR_W = 20;
   localparam int PX_W   = $clog2(COLS);
   localparam int PY_W   = $clog2(ROWS);

   logic clk = 1'b0;
   logic rst_n;
   logic stop1, stop3;
   logic sat1, abort1, sat3, abort3;
   logic [31:0] cnt1, cnt3;

   always #10 clk = ~clk;

   pixel_accum_rmw_if #(.DATA_W(DATA_W), .SRAM_W(SRAM_W), .ADDR_W(ADDR_W), .PX_W(PX_W), .PY_W(PY_W)) if1 ();
   pixel_accum_rmw_if #(.DATA_W(DATA_W), .SRAM_W(SRAM_W), .ADDR_W(ADDR_W), .PX_W(PX_W), .PY_W(PY_W)) if3 ();

   pixel_accum_rmw #(.DATA_W(DATA_W), .SRAM_W(SRAM_W), .ACC_W(ACC_W), .COLS(COLS), .ROWS(ROWS),
                     .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
      .i_50M_clk(clk), .i_rst_n(rst_n), .acc_if(if1), .i_stop(stop1),
      .o_sat(sat1), .o_abort(abort1), .o_op_cnt(cnt1));

   pixel_accum_rmw #(.DATA_W(DATA_W), .SRAM_W(SRAM_W), .ACC_W(ACC_W), .COLS(COLS), .ROWS(ROWS),
                     .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
      .i_50M_clk(clk), .i_rst_n(rst_n), .acc_if(if3), .i_stop(stop3),
      .o_sat(sat3), .o_abort(abort3), .o_op_cnt(cnt3));

   // SRAM model, latency 1: returns the per-vector word in the cycle after the read strobe
   logic [15:0] sram_val1 = '0;
   logic        pipe1 = 1'b0;
   always @(posedge clk) pipe1 <= if1.o_sram_oe;
   assign if1.i_sram_rdata = pipe1 ? sram_val1 : 16'hA5A5;

   // SRAM model, latency 3: small memory indexed by the low address bits
   logic [2:0]  pipe3 = '0;
   logic [15:0] rdq3 = '0;
   logic [15:0] mem3 [16] = '{default: '0};
   always @(posedge clk) begin
      pipe3 <= {pipe3[1:0], if3.o_sram_oe};
      if (if3.o_sram_oe) rdq3 <= mem3[if3.o_sram_addr[3:0]];
      if (if3.o_sram_we) mem3[if3.o_sram_addr[3:0]] <= if3.o_sram_wdata;
   end
   assign if3.i_sram_rdata = pipe3[2] ? rdq3 : 16'h5A5A;

   int checks = 0;
   int errors = 0;
   int excl_viol = 0;
   int exp_cnt1 = 0;

   always @(negedge clk) begin
      if ((if1.o_sram_oe && if1.o_sram_we) || (if3.o_sram_oe && if3.o_sram_we)) excl_viol++;
   end

   typedef struct {
      logic        mode;
      int          px;
      int          py;
      logic [16:0] nd;
      logic [16:0] od;
      logic [15:0] rd;
      logic [15:0] exp_wd;
      logic [19:0] exp_addr;
      logic        exp_sat;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic drive1(input logic mode, input int px, input int py,
                         input logic [16:0] nd, input logic [16:0] od, input logic [15:0] rd);
      if1.i_mode     = mode;
      if1.i_px       = PX_W'(px);
      if1.i_py       = PY_W'(py);
      if1.i_new_data = nd;
      if1.i_old_data = od;
      sram_val1      = rd;
      if1.i_valid    = 1'b1;
   endtask

   // Waits for the accept cycle, then drops valid at the start of the following cycle.
   task automatic start1(input string name);
      bit ok = 0;
      for (int t = 0; t < 20; t++) begin
         if (if1.o_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      if1.i_valid = 1'b0;
   endtask

   task automatic run_op(input vec_t v, input string name);
      int          lat = 0;
      int          oe_n = 0;
      int          sat_n = 0;
      bit          seen = 0;
      logic [15:0] wd = '0;
      logic [19:0] wa = '0;
      drive1(v.mode, v.px, v.py, v.nd, v.od, v.rd);
      start1(name);
      for (int k = 1; k <= 12 && !seen; k++) begin
         if (if1.o_sram_oe) oe_n++;
         if (sat1) sat_n++;
         if (if1.o_sram_we) begin
            seen = 1;
            lat  = k;
            wd   = if1.o_sram_wdata;
            wa   = if1.o_sram_addr;
         end
         @(negedge clk);
      end
      exp_cnt1++;
      chk({name, "_lat"},   lat,   v.exp_lat);
      chk({name, "_wdata"}, wd,    v.exp_wd);
      chk({name, "_addr"},  wa,    v.exp_addr);
      chk({name, "_sat"},   sat_n, {31'd0, v.exp_sat});
      chk({name, "_oe"},    oe_n,  {31'd0, v.mode});
      chk({name, "_cnt"},   cnt1,  exp_cnt1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int abort_n, we_n, rdy_n, acc_n, oe_n;
      int a3[2];
      int w3[2];
      logic [15:0] wd3[2];

      vecs[0] = '{1'b0,   3,   2, 17'd1000,   17'd200, 16'd0,      16'd200,    20'd1283,   1'b0, 2};
      vecs[1] = '{1'b1,   3,   2, 17'd500,    17'd100, 16'd200,    16'd300,    20'd1283,   1'b0, 3};
      vecs[2] = '{1'b1,   3,   2, 17'd0,      17'd100, 16'd10,     16'd0,      20'd1283,   1'b1, 3};
      vecs[3] = '{1'b1,   3,   2, 17'd131071, 17'd0,   16'hFFFF,   16'hFFFF,   20'd1283,   1'b1, 3};
      vecs[4] = '{1'b0, 639, 479, 17'd5,      17'd9,   16'd0,      16'd0,      20'd307199, 1'b1, 2};
      vecs[5] = '{1'b0,   0,   0, 17'd131071, 17'd0,   16'd0,      16'h7FFF,   20'd0,      1'b0, 2};
      vecs[6] = '{1'b1,  10,   0, 17'd3,      17'd0,   16'h8000,   16'h8000,   20'd10,     1'b0, 3};
      vecs[7] = '{1'b1,  10,   0, 17'd3,      17'd0,   16'hFFFF,   16'hFFFF,   20'd10,     1'b0, 3};
      vecs[8] = '{1'b0,   1,   1, 17'd0,      17'd0,   16'd0,      16'd0,      20'd641,    1'b0, 2};

      rst_n = 1'b0;
      stop1 = 1'b0;
      stop3 = 1'b0;
      if1.i_valid = 1'b0; if1.i_mode = 1'b0; if1.i_px = '0; if1.i_py = '0;
      if1.i_new_data = '0; if1.i_old_data = '0;
      if3.i_valid = 1'b0; if3.i_mode = 1'b0; if3.i_px = '0; if3.i_py = '0;
      if3.i_new_data = '0; if3.i_old_data = '0;
      repeat (2) @(negedge clk);

      chk("rst_ready", if1.o_ready, 0);
      chk("rst_we",    if1.o_sram_we, 0);
      chk("rst_oe",    if1.o_sram_oe, 0);
      chk("rst_addr",  if1.o_sram_addr, 0);
      chk("rst_wdata", if1.o_sram_wdata, 0);
      chk("rst_cnt",   cnt1, 0);
      chk("rst_sat",   sat1, 0);
      chk("rst_abort", abort1, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", if1.o_ready, 1);

      // reset pulse while a read is outstanding
      drive1(1'b1, 3, 2, 17'd500, 17'd100, 16'd200);
      start1("rstrd");
      chk("rstrd_oe", if1.o_sram_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("rstrd_oe_cleared", if1.o_sram_oe, 0);
      chk("rstrd_ready_low", if1.o_ready, 0);
      chk("rstrd_addr_cleared", if1.o_sram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstrd_ready", if1.o_ready, 1);
      we_n = 0;
      repeat (5) begin
         if (if1.o_sram_we) we_n++;
         @(negedge clk);
      end
      chk("rstrd_no_we", we_n, 0);
      chk("rstrd_cnt", cnt1, 0);

      for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("v%0d", i));

      // stop held during the read: one abort pulse, no write, ready stays low until stop falls
      drive1(1'b1, 5, 5, 17'd10, 17'd0, 16'd7);
      start1("stoprd");
      stop1 = 1'b1;
      abort_n = 0; we_n = 0; rdy_n = 0;
      repeat (4) begin
         @(negedge clk);
         if (abort1) abort_n++;
         if (if1.o_sram_we) we_n++;
         if (if1.o_ready) rdy_n++;
      end
      chk("stoprd_abort", abort_n, 1);
      chk("stoprd_no_we", we_n, 0);
      chk("stoprd_ready_low", rdy_n, 0);
      stop1 = 1'b0;
      #1;
      chk("stoprd_ready_back", if1.o_ready, 1);
      chk("stoprd_cnt", cnt1, exp_cnt1);

      // stop in the modify cycle of an init op
      @(negedge clk);
      drive1(1'b0, 5, 5, 17'd10, 17'd0, 16'd0);
      start1("stopmod");
      stop1 = 1'b1;
      @(negedge clk);
      chk("stopmod_abort", abort1, 1);
      chk("stopmod_ready_low", if1.o_ready, 0);
      stop1 = 1'b0;
      @(negedge clk);
      chk("stopmod_abort_once", abort1, 0);
      chk("stopmod_cnt", cnt1, exp_cnt1);

      // stop during the write: the write completes and no abort is raised
      drive1(1'b1, 3, 2, 17'd500, 17'd100, 16'd200);
      start1("stopwr");
      @(negedge clk);
      @(negedge clk);
      chk("stopwr_we", if1.o_sram_we, 1);
      chk("stopwr_wdata", if1.o_sram_wdata, 300);
      stop1 = 1'b1;
      @(negedge clk);
      exp_cnt1++;
      chk("stopwr_no_abort", abort1, 0);
      chk("stopwr_cnt", cnt1, exp_cnt1);
      stop1 = 1'b0;
      @(negedge clk);
      run_op(vecs[1], "after_stop");

      // RD_LAT=3: valid held through two ops to the same pixel
      if3.i_mode = 1'b1; if3.i_px = PX_W'(7); if3.i_py = PY_W'(1);
      if3.i_new_data = 17'd400; if3.i_old_data = 17'd0;
      if3.i_valid = 1'b1;
      acc_n = 0; we_n = 0; oe_n = 0;
      a3 = '{-1, -1}; w3 = '{-1, -1}; wd3 = '{16'd0, 16'd0};
      for (int t = 0; t < 40 && we_n < 2; t++) begin
         if (if3.i_valid && if3.o_ready) begin
            if (acc_n < 2) a3[acc_n] = t;
            acc_n++;
         end
         if (if3.o_sram_oe) oe_n++;
         if (if3.o_sram_we) begin
            chk($sformatf("b2b_addr%0d", we_n), if3.o_sram_addr, 647);
            if (we_n < 2) begin
               w3[we_n]  = t;
               wd3[we_n] = if3.o_sram_wdata;
            end
            we_n++;
            if (we_n == 1) if3.i_new_data = 17'd40;
            if (we_n == 2) if3.i_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("b2b_accepts", acc_n, 2);
      chk("b2b_writes", we_n, 2);
      chk("b2b_oe", oe_n, 2);
      chk("b2b_lat0", w3[0] - a3[0], 5);
      chk("b2b_lat1", w3[1] - a3[1], 5);
      chk("b2b_next_accept", a3[1] - w3[0], 1);
      chk("b2b_wdata0", wd3[0], 100);
      chk("b2b_wdata1", wd3[1], 110);
      chk("b2b_cnt", cnt3, 2);
      chk("b2b_sat", sat3, 0);
      chk("b2b_abort", abort3, 0);

      chk("oe_we_exclusive", excl_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
